// File: rtl/concat_replicate_packer_pkg.sv
// -----------------------------------------------------------------------------
// concat_packer_pkg
// Shared definitions for the concat/replicate packer: the mode encoding seen
// on the input side and the two-state fill machine.
// Optional build macro used by the packer: CONCAT_PACKER_PARITY_EN.
// -----------------------------------------------------------------------------
package concat_packer_pkg;

    localparam logic MODE_CONCAT    = 1'b0;
    localparam logic MODE_REPLICATE = 1'b1;

    typedef enum logic {
        ST_EMPTY,   // no fields held in the accumulator
        ST_FILL     // concat word in progress
    } state_t;

endpackage

// File: rtl/concat_replicate_packer_if.sv
// -----------------------------------------------------------------------------
// concat_replicate_packer_if
// Bundles the narrow input stream and the wide output stream of the packer.
//   in_valid/in_ready/in_data/in_last/mode : producer side (field stream)
//   out_valid/out_ready/out_data/out_count : consumer side (packed words)
//   out_parity                             : only with CONCAT_PACKER_PARITY_EN
// Modports:
//   master : the environment (drives fields, accepts words)
//   slave  : the packer itself
// -----------------------------------------------------------------------------
interface concat_replicate_packer_if #(
    parameter int IN_W       = 4,
    parameter int NUM_FIELDS = 4
);
    localparam int OUT_W = IN_W * NUM_FIELDS;
    localparam int CNT_W = $clog2(NUM_FIELDS + 1);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;

`ifdef CONCAT_PACKER_PARITY_EN
    logic             out_parity;

    modport master (
        output in_valid, in_data, in_last, mode, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_parity
    );

    modport slave (
        input  in_valid, in_data, in_last, mode, out_ready,
        output in_ready, out_valid, out_data, out_count, out_parity
    );
`else
    modport master (
        output in_valid, in_data, in_last, mode, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, mode, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
`endif

endinterface

// File: rtl/concat_replicate_packer.sv
// -----------------------------------------------------------------------------
// concat_replicate_packer
// Builds OUT_W-bit words from IN_W-bit fields. Concat mode packs fields
// MSB-first ({f0,f1,...}, unfilled low slots zero, in_last closes early);
// replicate mode expands one field to {NUM_FIELDS{f}}. A single output
// register plus the fill accumulator sustain one field per cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : concat_replicate_packer_if.slave (both handshakes, data, count)
// Optional feature macro: CONCAT_PACKER_PARITY_EN adds bus.out_parity, the
// registered XOR-reduce of out_data.
// -----------------------------------------------------------------------------
module concat_replicate_packer
    import concat_packer_pkg::*;
#(
    parameter int IN_W       = 4,
    parameter int NUM_FIELDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    concat_replicate_packer_if.slave  bus
);
    localparam int OUT_W = IN_W * NUM_FIELDS;
    localparam int CNT_W = $clog2(NUM_FIELDS + 1);

    state_t           r_state;
    logic [OUT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_fill;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_drain;
    logic             w_is_rep;
    logic             w_complete;
    logic [CNT_W-1:0] w_slot;
    logic [CNT_W-1:0] w_next_fill;
    logic [OUT_W-1:0] w_place;
    logic [OUT_W-1:0] w_next_acc;
    logic [OUT_W-1:0] w_load_data;
    logic [CNT_W-1:0] w_load_count;

    // The output register is the only buffer, so a field may enter only when
    // that register is free or is being emptied this cycle.
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_drain    = r_out_valid && bus.out_ready;

    // Mode is only looked at on the first field of a word; ST_FILL itself
    // records that the word in progress is a concat word.
    assign w_is_rep = (r_state == ST_EMPTY) && (bus.mode == MODE_REPLICATE);

    // NOTE: every signal in this block is assigned on every path before use,
    // so no latch can be inferred.
    always_comb begin
        w_slot      = (r_state == ST_FILL) ? r_fill : '0;
        w_next_fill = w_slot + 1'b1;
        // Slot 0 is the MSB field; w_slot never exceeds NUM_FIELDS-1 here.
        w_place     = OUT_W'(bus.in_data) << ((NUM_FIELDS - 1 - int'(w_slot)) * IN_W);
        w_next_acc  = ((r_state == ST_FILL) ? r_acc : '0) | w_place;
        // Fill count stops at NUM_FIELDS because reaching it always completes.
        w_complete  = w_is_rep || bus.in_last || (w_next_fill == CNT_W'(NUM_FIELDS));
        w_load_data  = w_is_rep ? {NUM_FIELDS{bus.in_data}} : w_next_acc;
        w_load_count = w_is_rep ? CNT_W'(NUM_FIELDS) : w_next_fill;
    end

`ifdef CONCAT_PACKER_PARITY_EN
    logic r_out_parity;
`endif

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_acc       <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
`ifdef CONCAT_PACKER_PARITY_EN
            r_out_parity <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                if (w_complete) begin
                    r_state <= ST_EMPTY;
                    r_acc   <= '0;
                    r_fill  <= '0;
                end else begin
                    r_state <= ST_FILL;
                    r_acc   <= w_next_acc;
                    r_fill  <= w_next_fill;
                end
            end

            // A completing beat wins over a drain so back-to-back words keep
            // out_valid high; otherwise the register holds until drained.
            if (w_accept && w_complete) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_load_data;
                r_out_count <= w_load_count;
`ifdef CONCAT_PACKER_PARITY_EN
                r_out_parity <= ^w_load_data;
`endif
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;
`ifdef CONCAT_PACKER_PARITY_EN
    assign bus.out_parity = r_out_parity;
`endif

endmodule

// File: tb/tb_concat_replicate_packer.sv
// -----------------------------------------------------------------------------
// tb_concat_replicate_packer
// Self-checking bench for concat_replicate_packer (IN_W=4, NUM_FIELDS=4).
// Expected words are pushed to a scoreboard when their completing field is
// driven; a monitor pops and compares on every output transfer. Scenario tasks
// add inline checks for timing, backpressure and reset behaviour.
// Honours CONCAT_PACKER_PARITY_EN when defined.
// -----------------------------------------------------------------------------
module tb_concat_replicate_packer;

    localparam int IN_W  = 4;
    localparam int NF    = 4;
    localparam int OUT_W = IN_W * NF;
    localparam int CNT_W = $clog2(NF + 1);

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [CNT_W-1:0] count;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    bit   ok_main;
    bit   ok_side;

    always #5 clk = ~clk;

    concat_replicate_packer_if #(.IN_W(IN_W), .NUM_FIELDS(NF)) bus ();

    concat_replicate_packer #(.IN_W(IN_W), .NUM_FIELDS(NF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Scoreboard monitor: a transfer is out_valid && out_ready at the edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word got data=%h count=%0d, none expected",
                         bus.out_data, bus.out_count);
            end else begin
                mon_e = sb.pop_front();
                if (bus.out_data !== mon_e.data || bus.out_count !== mon_e.count) begin
                    errors++;
                    $display("FAIL word got data=%h count=%0d, want data=%h count=%0d",
                             bus.out_data, bus.out_count, mon_e.data, mon_e.count);
                end
`ifdef CONCAT_PACKER_PARITY_EN
                checks++;
                if (bus.out_parity !== ^mon_e.data) begin
                    errors++;
                    $display("FAIL parity got %b want %b", bus.out_parity, ^mon_e.data);
                end
`endif
            end
        end
    end

    // Drive one field and wait (bounded) until it is accepted; returns at
    // posedge+1 after the accepting edge.
    task automatic send(input logic [IN_W-1:0] d, input logic last, input logic m,
                        output bit ok);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.mode     = m;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            errors++;
            $display("FAIL send_timeout field %h not accepted within 50 cycles", d);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain_wait();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout %0d words still expected", sb.size());
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_count !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b data=%h count=%0d want 0/0000/0",
                     bus.out_valid, bus.out_data, bus.out_count);
        end
`ifdef CONCAT_PACKER_PARITY_EN
        checks++;
        if (bus.out_parity !== 1'b0) begin
            errors++;
            $display("FAIL reset_parity got %b want 0", bus.out_parity);
        end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_concat_full();
        bus.out_ready = 1'b1;
        send(4'b1010, 1'b0, 1'b0, ok_main);
        send(4'b0101, 1'b0, 1'b0, ok_main);
        send(4'b1111, 1'b0, 1'b0, ok_main);
        sb.push_back('{data: 16'hA5F0, count: 3'd4});
        send(4'b0000, 1'b0, 1'b0, ok_main);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hA5F0) begin
            errors++;
            $display("FAIL concat_latency got valid=%b data=%h want 1/a5f0",
                     bus.out_valid, bus.out_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL concat_pulse got valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_replicate();
        bus.out_ready = 1'b1;
        sb.push_back('{data: 16'hAAAA, count: 3'd4});
        send(4'b1010, 1'b1, 1'b1, ok_main);  // in_last ignored in replicate
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hAAAA) begin
            errors++;
            $display("FAIL replicate_first got valid=%b data=%h want 1/aaaa",
                     bus.out_valid, bus.out_data);
        end
        sb.push_back('{data: 16'h5555, count: 3'd4});
        send(4'b0101, 1'b0, 1'b1, ok_main);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h5555) begin
            errors++;
            $display("FAIL replicate_b2b got valid=%b data=%h want 1/5555",
                     bus.out_valid, bus.out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_concat_last();
        bus.out_ready = 1'b1;
        send(4'b1100, 1'b0, 1'b0, ok_main);
        sb.push_back('{data: 16'hC300, count: 3'd2});
        send(4'b0011, 1'b1, 1'b0, ok_main);
        checks++;
        if (bus.out_data !== 16'hC300 || bus.out_count !== 3'd2) begin
            errors++;
            $display("FAIL partial_word got data=%h count=%0d want c300/2",
                     bus.out_data, bus.out_count);
        end
        sb.push_back('{data: 16'h9000, count: 3'd1});
        send(4'b1001, 1'b1, 1'b0, ok_main);
        checks++;
        if (bus.out_data !== 16'h9000 || bus.out_count !== 3'd1) begin
            errors++;
            $display("FAIL msb_restart got data=%h count=%0d want 9000/1",
                     bus.out_data, bus.out_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        send(4'b1010, 1'b0, 1'b0, ok_main);
        send(4'b0101, 1'b0, 1'b0, ok_main);
        send(4'b1111, 1'b0, 1'b0, ok_main);
        sb.push_back('{data: 16'hA5F0, count: 3'd4});
        send(4'b0000, 1'b0, 1'b0, ok_main);
        fork
            begin
                send(4'b1000, 1'b0, 1'b0, ok_side);
                send(4'b0100, 1'b0, 1'b0, ok_side);
                send(4'b0010, 1'b0, 1'b0, ok_side);
                sb.push_back('{data: 16'h8421, count: 3'd4});
                send(4'b0001, 1'b0, 1'b0, ok_side);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                        bus.out_data !== 16'hA5F0) begin
                        errors++;
                        $display("FAIL stall_hold got ready=%b valid=%b data=%h want 0/1/a5f0",
                                 bus.in_ready, bus.out_valid, bus.out_data);
                    end
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain_wait();
    endtask

    task automatic test_reset_mid_word();
        bus.out_ready = 1'b0;
        send(4'b0111, 1'b0, 1'b1, ok_main);  // pending word, discarded by reset
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_count !== '0) begin
            errors++;
            $display("FAIL async_reset got valid=%b data=%h count=%0d want 0/0000/0",
                     bus.out_valid, bus.out_data, bus.out_count);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(4'b1110, 1'b0, 1'b0, ok_main);
        send(4'b1101, 1'b0, 1'b0, ok_main);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_partial got valid=%b want 0", bus.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(4'b0001, 1'b0, 1'b0, ok_main);
        send(4'b0010, 1'b0, 1'b0, ok_main);
        send(4'b0011, 1'b0, 1'b0, ok_main);
        sb.push_back('{data: 16'h1234, count: 3'd4});
        send(4'b0100, 1'b0, 1'b0, ok_main);
        drain_wait();
    endtask

    task automatic test_mode_latch();
        bus.out_ready = 1'b1;
        send(4'b1010, 1'b0, 1'b0, ok_main);
        send(4'b0101, 1'b0, 1'b1, ok_main);
        send(4'b1111, 1'b0, 1'b1, ok_main);
        sb.push_back('{data: 16'hA5F0, count: 3'd4});
        send(4'b0000, 1'b0, 1'b1, ok_main);
        drain_wait();
`ifdef CONCAT_PACKER_PARITY_EN
        sb.push_back('{data: 16'h8000, count: 3'd1});
        send(4'b1000, 1'b1, 1'b0, ok_main);
        checks++;
        if (bus.out_parity !== 1'b1) begin
            errors++;
            $display("FAIL parity_8000 got %b want 1", bus.out_parity);
        end
        drain_wait();
`endif
    endtask

    initial begin
        test_reset();
        test_concat_full();
        test_replicate();
        test_concat_last();
        test_backpressure();
        test_reset_mid_word();
        test_mode_latch();
        drain_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
